// File: rtl/patid_enc_pipe.sv
// patid_enc_pipe
//   Two-stage CLCT pattern-ID encoder. Stage 1 captures the two valid-pattern
//   flags and pattern IDs on strobe. Stage 2 folds them into one OUT_W-bit
//   code and registers it with a one-cycle valid pulse and an error flag.
//   Results appear exactly two clocks after the strobe, fully pipelined.
//
//   Code map:
//     lct0 only      -> clct0_pid (zero-extended)
//     both valid     -> clct1_pid*NPAT + clct0_pid + NPAT (truncated)
//     lct1 only      -> 2^OUT_W-2
//     neither        -> 2^OUT_W-1
//     any error      -> 2^OUT_W-1 with out_err=1
//
//   Optional feature macro: PATID_CNT_EN
//     defined   : err_sticky and four saturating per-category counters
//     undefined : err_sticky and counters are constant 0, cnt_clr ignored
//
// Ports
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   strobe            : inputs below are valid this cycle (one-cycle qualifier)
//   lct0_vpf/lct1_vpf : CLCT0/CLCT1 valid-pattern flags
//   clct0_pid/clct1_pid : CLCT0/CLCT1 pattern IDs (PID_W bits)
//   cnt_clr           : synchronous clear of counters and err_sticky
//   out_pid           : registered combined code, held while out_vld=0
//   out_vld           : one-cycle pulse marking out_pid/out_err as new
//   out_err           : per-result error qualifier, aligned with out_vld
//   err_sticky        : set by any error result, cleared by cnt_clr/reset
//   cnt_single/cnt_pair/cnt_lct1only/cnt_none : per-category event counters
//
// Handshake: no back-pressure. A strobe is always accepted; its result is
// presented with out_vld exactly two clocks later for one cycle.

module patid_enc_pipe #(
    parameter int PID_W = 3,
    parameter int NPAT  = 5,
    parameter int OUT_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic             lct0_vpf,
    input  logic             lct1_vpf,
    input  logic [PID_W-1:0] clct0_pid,
    input  logic [PID_W-1:0] clct1_pid,
    input  logic             cnt_clr,
    output logic [OUT_W-1:0] out_pid,
    output logic             out_vld,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_pair,
    output logic [CNT_W-1:0] cnt_lct1only,
    output logic [CNT_W-1:0] cnt_none
);

    localparam logic [OUT_W-1:0] CODE_NONE = '1;
    localparam logic [OUT_W-1:0] CODE_LCT1 = CODE_NONE - OUT_W'(1);
    localparam logic [31:0]      NPAT_U    = 32'(NPAT);
    // Pair codes at or above this value collide with the reserved codes.
    localparam logic [31:0]      PAIR_LIM  = (32'd1 << OUT_W) - 32'd2;

    // ---------------- stage 1: capture ----------------
    logic             s1_vld;
    logic             s1_vpf0;
    logic             s1_vpf1;
    logic [PID_W-1:0] s1_pid0;
    logic [PID_W-1:0] s1_pid1;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_vpf0 <= 1'b0;
            s1_vpf1 <= 1'b0;
            s1_pid0 <= '0;
            s1_pid1 <= '0;
        end else begin
            s1_vld <= strobe;
            if (strobe) begin
                s1_vpf0 <= lct0_vpf;
                s1_vpf1 <= lct1_vpf;
                s1_pid0 <= clct0_pid;
                s1_pid1 <= clct1_pid;
            end
        end
    end

    // ---------------- stage 2: encode ----------------
    logic [31:0]      pair_full;
    logic             pid0_bad;
    logic             pid1_bad;
    logic             enc_err;
    logic [OUT_W-1:0] enc_pid;

    always_comb begin
        pair_full = 32'(s1_pid1) * NPAT_U + 32'(s1_pid0) + NPAT_U;
        // A pid only counts as bad when its own vpf qualifies it.
        pid0_bad  = s1_vpf0 && (32'(s1_pid0) >= NPAT_U);
        pid1_bad  = s1_vpf1 && (32'(s1_pid1) >= NPAT_U);
        enc_err   = pid0_bad || pid1_bad ||
                    (s1_vpf0 && s1_vpf1 && (pair_full >= PAIR_LIM));
        enc_pid   = CODE_NONE;
        unique case ({s1_vpf1, s1_vpf0})
            2'b01:   enc_pid = OUT_W'(s1_pid0);
            2'b11:   enc_pid = pair_full[OUT_W-1:0];
            2'b10:   enc_pid = CODE_LCT1;
            default: enc_pid = CODE_NONE;
        endcase
        if (enc_err) begin
            enc_pid = CODE_NONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_vld <= 1'b0;
            out_err <= 1'b0;
            out_pid <= CODE_NONE;
        end else begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                out_pid <= enc_pid;
                out_err <= enc_err;
            end
        end
    end

    // ---------------- statistics ----------------
`ifdef PATID_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] single_q;
    logic [CNT_W-1:0] pair_q;
    logic [CNT_W-1:0] lct1_q;
    logic [CNT_W-1:0] none_q;
    logic             sticky_q;

    // Counters and sticky flag update on the same edge that raises out_vld,
    // so they already include the result being presented. cnt_clr wins
    // over a coincident increment.
    always_ff @(posedge clock) begin
        if (reset || cnt_clr) begin
            single_q <= '0;
            pair_q   <= '0;
            lct1_q   <= '0;
            none_q   <= '0;
            sticky_q <= 1'b0;
        end else if (s1_vld) begin
            unique case ({s1_vpf1, s1_vpf0})
                2'b01:   if (single_q != CNT_MAX) single_q <= single_q + CNT_W'(1);
                2'b11:   if (pair_q   != CNT_MAX) pair_q   <= pair_q   + CNT_W'(1);
                2'b10:   if (lct1_q   != CNT_MAX) lct1_q   <= lct1_q   + CNT_W'(1);
                default: if (none_q   != CNT_MAX) none_q   <= none_q   + CNT_W'(1);
            endcase
            if (enc_err) begin
                sticky_q <= 1'b1;
            end
        end
    end

    assign cnt_single   = single_q;
    assign cnt_pair     = pair_q;
    assign cnt_lct1only = lct1_q;
    assign cnt_none     = none_q;
    assign err_sticky   = sticky_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;

    assign cnt_single   = '0;
    assign cnt_pair     = '0;
    assign cnt_lct1only = '0;
    assign cnt_none     = '0;
    assign err_sticky   = 1'b0;
`endif

endmodule
